// File: rtl/aclint_ctrl.sv
// ---------------------------------------------------------------------------
// aclint_ctrl
//
// Single-hart ACLINT controller. Owns the machine timer (mtime / mtimecmp)
// and the machine software-interrupt bit (msip), serves them as
// memory-mapped registers on a simple request/response bus, and drives the
// interrupt-pending lines plus the live mtime value to the CSR unit.
//
// Register map (offset = bus_addr - BASE_ADDR, bus_addr[2:0] ignored):
//   0x0000  MSIP      bit 0 only, other bits read 0
//   0x4000  MTIMECMP  64-bit
//   0xBFF8  MTIME     64-bit
//   other   reads 0, writes dropped, no error
//
// Handshake: a request transfers in the cycle where bus_valid and bus_ready
// are both high. bus_ready is high only in IDLE, so at most one request is
// outstanding. The response is a single-cycle bus_rvalid pulse in the cycle
// after acceptance; bus_rdata is meaningful only while bus_rvalid is high and
// is 0 for writes. The requester holds bus_valid and its payload stable until
// it sees bus_ready high at a clock edge. There is no response back-pressure.
//
// Ports:
//   clk, rst                 core clock, asynchronous active-low reset
//   bus_valid / bus_ready    request handshake
//   bus_addr, bus_wen,       request payload (byte address, write flag,
//   bus_wdata, bus_wmask     write data, byte enables)
//   bus_rvalid, bus_rdata    one-cycle response
//   mtip, msip, mtime        outputs to the CSR unit
//
// Debug visibility: the FSM state is held in state_q (type state_t) and the
// prescaler in presc_q, both plain signals a checker can bind to.
// ---------------------------------------------------------------------------
module aclint_ctrl #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_valid,
    output logic        bus_ready,
    input  logic [63:0] bus_addr,
    input  logic        bus_wen,
    input  logic [63:0] bus_wdata,
    input  logic [7:0]  bus_wmask,
    output logic        bus_rvalid,
    output logic [63:0] bus_rdata,
    output logic        mtip,
    output logic        msip,
    output logic [63:0] mtime
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    // Offsets compared on 8-byte granularity (address bits [2:0] dropped).
    localparam logic [60:0] OFF_MSIP     = 61'h0000;
    localparam logic [60:0] OFF_MTIMECMP = 61'h0800;  // 0x4000 >> 3
    localparam logic [60:0] OFF_MTIME    = 61'h17FF;  // 0xBFF8 >> 3

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t        state_q,    state_d;
    logic          run_q,      run_d;       // low only in the cycle reset ends
    logic [PW-1:0] presc_q,    presc_d;
    logic [63:0]   mtime_q,    mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          msip_q,     msip_d;
    logic          mtip_q,     mtip_d;
    logic [63:0]   rdata_q,    rdata_d;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic [63:0] addr_off;
    logic        hit_msip;
    logic        hit_mtimecmp;
    logic        hit_mtime;
    logic        unused_off_bits;

    assign addr_off        = bus_addr - BASE_ADDR;
    assign hit_msip        = (addr_off[63:3] == OFF_MSIP);
    assign hit_mtimecmp    = (addr_off[63:3] == OFF_MTIMECMP);
    assign hit_mtime       = (addr_off[63:3] == OFF_MTIME);
    assign unused_off_bits = ^addr_off[2:0];

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic logic [63:0] merge_bytes(
        input logic [63:0] old_v,
        input logic [63:0] new_v,
        input logic [7:0]  mask
    );
        logic [63:0] res;
        for (int i = 0; i < 8; i++) begin
            res[8*i +: 8] = mask[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Combinational next state
    // -----------------------------------------------------------------------
    logic        tick;
    logic        accept;
    logic [63:0] mtime_inc;
    logic [63:0] read_val;

    assign tick   = (presc_q == PRESC_LAST);
    assign accept = bus_valid & bus_ready;

    always_comb begin
        read_val = 64'h0;
        if (hit_msip) begin
            read_val = {63'h0, msip_q};
        end else if (hit_mtimecmp) begin
            read_val = mtimecmp_q;
        end else if (hit_mtime) begin
            read_val = mtime_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        run_d      = 1'b1;
        presc_d    = tick ? '0 : (presc_q + PRESC_ONE);
        mtime_inc  = tick ? (mtime_q + 64'd1) : mtime_q;
        mtime_d    = mtime_inc;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        // Compare uses current register values, so a change to either
        // operand shows on mtip one cycle after it lands in the register.
        mtip_d     = (mtime_q >= mtimecmp_q);
        rdata_d    = 64'h0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RESP;
                    if (bus_wen) begin
                        if (hit_msip && bus_wmask[0]) begin
                            msip_d = bus_wdata[0];
                        end
                        if (hit_mtimecmp) begin
                            mtimecmp_d = merge_bytes(mtimecmp_q, bus_wdata, bus_wmask);
                        end
                        // Merging over the incremented value means written
                        // bytes win and unwritten bytes still advance; a tick
                        // in this cycle is not carried forward separately.
                        if (hit_mtime) begin
                            mtime_d = merge_bytes(mtime_inc, bus_wdata, bus_wmask);
                        end
                    end else begin
                        // Read data comes from pre-write, pre-tick values.
                        rdata_d = read_val;
                    end
                end
            end
            ST_RESP: begin
                // rdata_d defaults to 0 so bus_rdata idles at 0 again after
                // the response cycle.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            run_q      <= 1'b0;
            presc_q    <= '0;
            mtime_q    <= 64'h0;
            mtimecmp_q <= {64{1'b1}};
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            rdata_q    <= 64'h0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            rdata_q    <= rdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // run_q keeps bus_ready low in reset and in the cycle reset is released.
    assign bus_ready  = run_q && (state_q == ST_IDLE);
    assign bus_rvalid = (state_q == ST_RESP);
    assign bus_rdata  = rdata_q;
    assign mtip       = mtip_q;
    assign msip       = msip_q;
    assign mtime      = mtime_q;

endmodule

// File: tb/tb_aclint_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aclint_ctrl
//
// Two instances share one bus driver: dut1 (TICK_DIV=1) and dut4
// (TICK_DIV=4). 'sel' routes bus_valid to one of them and picks which one's
// outputs the monitor watches. Inputs change #1 after posedge or at negedge;
// outputs are sampled at negedge.
// ---------------------------------------------------------------------------
module tb_aclint_ctrl;

    localparam logic [63:0] BASE     = 64'h0000_0000_0200_0000;
    localparam logic [63:0] OFF_MSIP = 64'h0000;
    localparam logic [63:0] OFF_CMP  = 64'h4000;
    localparam logic [63:0] OFF_TIME = 64'hBFF8;
    localparam logic [63:0] OFF_BAD  = 64'h0008;
    localparam logic [63:0] ONES     = {64{1'b1}};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;  // cycles since reset release; 0 in the release cycle
    always @(posedge clk) begin
        if (rst) cyc <= cyc + 1;
    end

    // ---------------- bus ----------------
    logic        sel = 1'b0;
    logic        bus_valid = 1'b0;
    logic [63:0] bus_addr = 64'h0;
    logic        bus_wen = 1'b0;
    logic [63:0] bus_wdata = 64'h0;
    logic [7:0]  bus_wmask = 8'h0;

    logic        valid1, ready1, rvalid1, mtip1, msip1;
    logic [63:0] rdata1, mtime1;
    logic        valid4, ready4, rvalid4, mtip4, msip4;
    logic [63:0] rdata4, mtime4;

    assign valid1 = bus_valid & ~sel;
    assign valid4 = bus_valid & sel;

    logic        cur_ready, cur_rvalid;
    logic [63:0] cur_rdata;
    assign cur_ready  = sel ? ready4  : ready1;
    assign cur_rvalid = sel ? rvalid4 : rvalid1;
    assign cur_rdata  = sel ? rdata4  : rdata1;

    aclint_ctrl #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst),
        .bus_valid(valid1), .bus_ready(ready1), .bus_addr(bus_addr),
        .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
        .bus_rvalid(rvalid1), .bus_rdata(rdata1),
        .mtip(mtip1), .msip(msip1), .mtime(mtime1)
    );

    aclint_ctrl #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst),
        .bus_valid(valid4), .bus_ready(ready4), .bus_addr(bus_addr),
        .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
        .bus_rvalid(rvalid4), .bus_rdata(rdata4),
        .mtip(mtip4), .msip(msip4), .mtime(mtime4)
    );

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Handshake trace window
    logic       log_en = 1'b0;
    logic [7:0] ready_log = 8'h0;
    int         log_n = 0;
    int         log_rv = 0;

    always @(negedge clk) begin
        if (log_en) begin
            ready_log <= {ready_log[6:0], cur_ready};
            log_n     <= log_n + 1;
            if (cur_rvalid) log_rv <= log_rv + 1;
        end
        if (cur_rvalid) begin
            if (exp_q.size() == 0) check_eq("unexpected_rvalid", 64'd1, 64'd0);
            else                   check_eq("rdata", cur_rdata, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic to_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns #1 after the accepting edge, i.e. in
    // the response cycle. The expected response is queued up front.
    task automatic bus_req(input logic s, input logic wen, input logic [63:0] off,
                           input logic [63:0] wdata, input logic [7:0] wmask,
                           input logic [63:0] exp);
        int   waited;
        logic acc;
        waited    = 0;
        sel       = s;
        bus_valid = 1'b1;
        bus_wen   = wen;
        bus_addr  = BASE + off;
        bus_wdata = wdata;
        bus_wmask = wmask;
        exp_q.push_back(exp);
        while (1) begin
            @(negedge clk);
            acc = cur_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 16) begin
                check_eq("accept_timeout", 64'd0, 64'd1);
                void'(exp_q.pop_back());
                break;
            end
        end
        bus_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        // Reset values
        @(negedge clk);
        check_eq("rst_ready1",  64'(ready1),  64'd0);
        check_eq("rst_rvalid1", 64'(rvalid1), 64'd0);
        check_eq("rst_rdata1",  rdata1,       64'd0);
        check_eq("rst_mtime1",  mtime1,       64'd0);
        check_eq("rst_mtip1",   64'(mtip1),   64'd0);
        check_eq("rst_msip1",   64'(msip1),   64'd0);
        check_eq("rst_ready4",  64'(ready4),  64'd0);
        check_eq("rst_mtime4",  mtime4,       64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Free run: mtime1 counts every cycle, mtime4 every fourth
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("run_ready1", 64'(ready1), (k > 0) ? 64'd1 : 64'd0);
            check_eq("run_mtime1", mtime1, 64'(k));
            check_eq("run_mtime4", mtime4, 64'(k / 4));
            check_eq("run_mtip1",  64'(mtip1), 64'd0);
        end

        // Timer interrupt
        to_cycle();
        bus_req(1'b0, 1'b1, OFF_CMP, 64'd20, 8'hFF, 64'd0);
        while (cyc < 20) @(negedge clk);
        check_eq("cmp_mtime_at20", mtime1, 64'd20);
        check_eq("mtip_not_early", 64'(mtip1), 64'd0);
        @(negedge clk);
        check_eq("mtip_rise", 64'(mtip1), 64'd1);
        to_cycle();
        bus_req(1'b0, 1'b0, OFF_CMP, 64'd0, 8'h00, 64'd20);
        bus_req(1'b0, 1'b1, OFF_CMP, ONES, 8'hFF, 64'd0);
        @(negedge clk);
        check_eq("mtip_hold", 64'(mtip1), 64'd1);
        @(negedge clk);
        check_eq("mtip_fall", 64'(mtip1), 64'd0);

        // Software interrupt
        to_cycle();
        bus_req(1'b0, 1'b1, OFF_MSIP, 64'h1, 8'h01, 64'd0);
        @(negedge clk);
        check_eq("msip_set", 64'(msip1), 64'd1);
        to_cycle();
        bus_req(1'b0, 1'b0, OFF_MSIP, 64'h0, 8'h00, 64'h1);
        bus_req(1'b0, 1'b1, OFF_MSIP, 64'h0, 8'h00, 64'd0);
        @(negedge clk);
        check_eq("msip_mask0", 64'(msip1), 64'd1);
        to_cycle();
        bus_req(1'b0, 1'b1, OFF_MSIP, 64'h0, 8'h01, 64'd0);
        @(negedge clk);
        check_eq("msip_clear", 64'(msip1), 64'd0);
        to_cycle();
        bus_req(1'b0, 1'b1, OFF_MSIP, ONES, 8'hFF, 64'd0);
        bus_req(1'b0, 1'b0, OFF_MSIP, 64'h0, 8'h00, 64'h1);
        bus_req(1'b0, 1'b1, OFF_MSIP, 64'h0, 8'hFF, 64'd0);
        @(negedge clk);
        check_eq("msip_clear2", 64'(msip1), 64'd0);

        // Handshake: two back-to-back reads with bus_valid held high
        to_cycle();
        log_en = 1'b1;
        bus_req(1'b0, 1'b0, OFF_CMP, 64'h0, 8'h00, ONES);
        bus_req(1'b0, 1'b0, OFF_CMP, 64'h0, 8'h00, ONES);
        @(negedge clk);
        #1;
        log_en = 1'b0;
        check_eq("ready_pattern", 64'(ready_log[3:0]), 64'b1010);
        check_eq("ready_samples", 64'(log_n), 64'd4);
        check_eq("rvalid_pulses", 64'(log_rv), 64'd2);

        // MTIME read returns the accept-cycle value; addr[2:0] ignored
        to_cycle();
        bus_req(1'b0, 1'b0, OFF_TIME, 64'h0, 8'h00, 64'(cyc));
        bus_req(1'b0, 1'b0, OFF_TIME + 64'd4, 64'h0, 8'h00, 64'(cyc + 1));

        // Unmapped access
        to_cycle();
        bus_req(1'b0, 1'b0, OFF_BAD, 64'h0, 8'h00, 64'd0);
        @(negedge clk);
        check_eq("bad_rvalid_latency", 64'(rvalid1), 64'd1);
        to_cycle();
        bus_req(1'b0, 1'b1, OFF_BAD, ONES, 8'hFF, 64'd0);
        bus_req(1'b0, 1'b0, OFF_MSIP, 64'h0, 8'h00, 64'd0);
        bus_req(1'b0, 1'b0, OFF_CMP, 64'h0, 8'h00, ONES);
        @(negedge clk);
        check_eq("bad_write_mtime", mtime1, 64'(cyc));

        // Byte mask + tick collision on dut4 (prescaler phase == cyc % 4)
        to_cycle();
        while ((cyc % 4) != 1) to_cycle();
        bus_req(1'b1, 1'b1, OFF_TIME, 64'h0000_0001_0000_FFFF, 8'hFF, 64'd0);
        @(negedge clk);
        check_eq("mtime4_full_write", mtime4, 64'h0000_0001_0000_FFFF);
        bus_req(1'b1, 1'b1, OFF_TIME, 64'h0000_0000_0000_AABB, 8'h03, 64'd0);
        @(negedge clk);
        check_eq("mtime4_collision", mtime4, 64'h0000_0001_0001_AABB);
        repeat (3) @(negedge clk);
        check_eq("mtime4_hold", mtime4, 64'h0000_0001_0001_AABB);
        @(negedge clk);
        check_eq("mtime4_next_tick", mtime4, 64'h0000_0001_0001_AABC);

        // Wrap on dut1 (also hits mtime == mtimecmp)
        to_cycle();
        bus_req(1'b0, 1'b1, OFF_TIME, ONES, 8'hFF, 64'd0);
        @(negedge clk);
        check_eq("wrap_written", mtime1, ONES);
        check_eq("wrap_mtip_pre", 64'(mtip1), 64'd0);
        @(negedge clk);
        check_eq("wrap_zero", mtime1, 64'd0);
        check_eq("mtip_equal", 64'(mtip1), 64'd1);
        @(negedge clk);
        check_eq("mtip_after_wrap", 64'(mtip1), 64'd0);

        // Reset during the response cycle aborts the response
        to_cycle();
        bus_req(1'b0, 1'b0, OFF_MSIP, 64'h0, 8'h00, 64'd0);
        rst = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check_eq("abort_rvalid", 64'(rvalid1), 64'd0);
        check_eq("abort_ready",  64'(ready1),  64'd0);
        check_eq("abort_mtime",  mtime1,       64'd0);
        to_cycle();
        rst = 1'b1;
        repeat (3) to_cycle();
        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
